// File: rtl/dmem_port_arbiter_if.sv
// One requester port of the data-RAM arbiter: request handshake, payload and the
// one-cycle-later response.
interface dmem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic                  we;
    logic [1:0]            size;
    logic                  isUnsigned;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output valid, we, size, isUnsigned, addr, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  valid, we, size, isUnsigned, addr, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one byte-write data RAM between two requesters, with
// lane-enable generation, store-data replication and load extraction/extension.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_port_arbiter_if.slave    m0,
    dmem_port_arbiter_if.slave    m1,
    output logic                  ram_en,
    output logic [NUM_COL-1:0]    ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int unsigned OFF_W    = $clog2(NUM_COL);
    localparam int unsigned SH_W     = $clog2(DATA_WIDTH);
    localparam int unsigned HALF_REP = NUM_COL / 2;
    localparam int unsigned HALF_W   = 2 * COL_WIDTH;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic                  rrPtr;
    logic                  respValid;
    logic                  respOwner;
    logic                  respErr;
    logic [DATA_WIDTH-1:0] respData;

    logic                  grant0;
    logic                  grant1;
    logic                  granted;
    logic                  access;
    logic                  reqErr;

    logic                  selWe;
    logic [1:0]            selSize;
    logic                  selUns;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [DATA_WIDTH-1:0] selWdata;
    logic [OFF_W-1:0]      off;

    logic [NUM_COL-1:0]    laneBase;
    logic [DATA_WIDTH-1:0] repData;
    logic [SH_W-1:0]       shAmt;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] loadData;

    // Lone requester always wins; on contention rrPtr names the preferred side.
    assign grant0  = m0.valid & (~m1.valid | ~rrPtr);
    assign grant1  = m1.valid & (~m0.valid | rrPtr);
    assign granted = grant0 | grant1;

    always_comb begin
        selWe    = m0.we;
        selSize  = m0.size;
        selUns   = m0.isUnsigned;
        selAddr  = m0.addr;
        selWdata = m0.wdata;
        if (grant1) begin
            selWe    = m1.we;
            selSize  = m1.size;
            selUns   = m1.isUnsigned;
            selAddr  = m1.addr;
            selWdata = m1.wdata;
        end
    end

    assign off = selAddr[OFF_W-1:0];

    always_comb begin
        reqErr   = 1'b0;
        laneBase = '0;
        repData  = selWdata;
        unique case (selSize)
            SZ_BYTE: begin
                laneBase = NUM_COL'(1);
                repData  = {NUM_COL{selWdata[COL_WIDTH-1:0]}};
            end
            SZ_HALF: begin
                reqErr   = off[0];
                laneBase = NUM_COL'(3);
                repData  = {HALF_REP{selWdata[HALF_W-1:0]}};
            end
            SZ_WORD: begin
                reqErr   = |off;
                laneBase = '1;
            end
            default: reqErr = 1'b1;
        endcase
    end

    assign access   = granted & ~reqErr;
    assign ram_en   = access;
    assign ram_we   = (access & selWe) ? (laneBase << off) : '0;
    assign ram_addr = granted ? {selAddr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign ram_din  = (access & selWe) ? repData : '0;

    // Bring the addressed lane(s) down to bit 0, then extend to full width.
    assign shAmt   = SH_W'(off) * SH_W'(COL_WIDTH);
    assign shifted = ram_dout >> shAmt;

    always_comb begin
        loadData = ram_dout;
        if (selSize == SZ_BYTE) begin
            loadData = {{(DATA_WIDTH-COL_WIDTH){~selUns & shifted[COL_WIDTH-1]}},
                        shifted[COL_WIDTH-1:0]};
        end else if (selSize == SZ_HALF) begin
            loadData = {{(DATA_WIDTH-HALF_W){~selUns & shifted[HALF_W-1]}},
                        shifted[HALF_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rrPtr     <= 1'b0;
            respValid <= 1'b0;
            respOwner <= 1'b0;
            respErr   <= 1'b0;
            respData  <= '0;
        end else begin
            if (granted) begin
                rrPtr <= ~grant1;
            end
            respValid <= granted;
            respOwner <= grant1;
            respErr   <= granted & reqErr;
            respData  <= (access & ~selWe) ? loadData : '0;
        end
    end

    assign m0.ready  = grant0;
    assign m1.ready  = grant1;
    assign m0.rvalid = respValid & ~respOwner;
    assign m1.rvalid = respValid & respOwner;
    assign m0.err    = respValid & ~respOwner & respErr;
    assign m1.err    = respValid & respOwner & respErr;
    assign m0.rdata  = (respValid & ~respOwner) ? respData : '0;
    assign m1.rdata  = (respValid & respOwner) ? respData : '0;

endmodule
